mult_piped_2sc_stream: RTL and testbench
========================================

Name: mult_piped_2sc_stream

Overview:
- Parametrised, streaming, pipelined multiplier; successor to the fixed 8x8 two's-complement piped multiplier.
- Width and depth are configurable.
- Each transaction selects signed or unsigned mode.
- Adds a valid/ready handshake with full back-pressure and a tag passthrough for out-of-band IDs.
- Sits between datapath producers and consumers (filters, accumulators) that need one product per clock at fixed latency.

Parameters:
- WIDTH_A, 8, operand a width (>=2)
- WIDTH_B, 8, operand b width (>=2)
- STAGES, 8, pipeline latency in cycles (>=1)
- TAG_W, 4, width of sideband tag carried alongside each product (>=1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input transaction present
- in_ready  out  1  block accepts input this cycle
- in_a  in  WIDTH_A  operand a
- in_b  in  WIDTH_B  operand b
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_tag  in  TAG_W  sideband tag
- out_valid  out  1  product present
- out_ready  in  1  consumer accepts product
- out_y  out  WIDTH_A+WIDTH_B  product
- out_tag  out  TAG_W  tag of the transaction in out_y

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - out_y/out_tag hold stable while out_valid & ~out_ready.
- Stall rule:
  - advance = ~out_valid | out_ready.
  - in_ready = advance & ~reset.
  - When advance = 0, every stage holds. Stall is global; bubbles are not collapsed.
- Latency:
  - A transaction accepted at edge N appears at out_valid after edge N+STAGES, assuming no stall.
  - Each stall cycle adds one cycle.
  - Throughput is one product per clock.
- Pipeline storage: per stage one valid bit, the product, and the tag. Valid bit 0 enters when advance & ~in_valid (bubble).
- Arithmetic (computed before stage 0 register; later stages are pure delay for retiming):
  - Unsigned: out_y = a*b, full width, no truncation.
  - Signed: operands sign-extended, full-precision product, WIDTH_A+WIDTH_B bits two's-complement.
  - Most-negative * most-negative = +2^(WIDTH_A+WIDTH_B-2); no overflow is possible.
  - A zero product is always all-zeros; no negative zero.
  - in_signed is latched per transaction; mixed modes back-to-back are legal.
- Reset (synchronous):
  - All stage valid bits are 0; out_valid = 0, out_y = 0, out_tag = 0.
  - in_ready = 0 while reset is high and 1 on the first cycle after release.
  - Reset mid-operation discards all in-flight transactions; nothing emerges afterwards.
- Simultaneous events:
  - With the pipeline full, out_ready=1 and in_valid=1 in the same cycle: output consumed and new input accepted in that cycle; no loss, no duplicate.
  - in_valid while in_ready=0: no acceptance; the producer must hold.
- Invalid stages never drive out_valid; out_y content under out_valid=0 is don't-care (except after reset: 0).

Decomposition:
- Package mult_pkg:
  - function prod_width(wa,wb) = wa+wb.
  - function mul_2sc_u(a,b,signed_mode): the width-generic multiply used at stage-0 input.
  - Localparam defaults: WIDTH_A, WIDTH_B, STAGES, TAG_W.
- Sub-module mult_stall_pipe: generic STAGES-deep register chain of {valid, data} with a common enable (advance) and synchronous reset. It is instantiated once with data = {product, tag}; the top level holds only the handshake and arithmetic.

Test Plan:
- Defaults, signed: a=0x80, b=0x80, tag=3 -> after 8 cycles out_y=0x4000, out_tag=3. Also a=0x80, b=0x7F -> 0xC080; a=0xFF, b=0x01 -> 0xFFFF; a=0x00, b=0x85 -> 0x0000.
- Unsigned: a=0xFF, b=0xFF, in_signed=0 -> 0xFE01. Interleave with signed 0xFF*0xFF -> 0x0001 on the next cycle; both arrive in order on consecutive cycles.
- Streaming: 20 back-to-back random transactions with out_ready=1 -> first out_valid exactly 8 cycles after first accept; then one result per cycle; all match the reference model and tags are in order.
- Back-pressure: fill the pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, out_y/out_tag stable. Release -> no loss, no duplication; the accept and consume counts match.
- Reset mid-stream: 4 transactions in flight, assert reset for 1 cycle -> out_valid=0, out_y=0 next cycle; no stale results emerge in the following 10 cycles; in_ready=1 after release.
- Parameter sweep: WIDTH_A=12, WIDTH_B=5, STAGES=1 -> -2048*-16 = 0x08000 (17 bits) at 1-cycle latency; STAGES=3 gives 3-cycle latency.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared defaults and the width-generic multiply evaluated ahead of the
// first pipeline register.
package mult_pkg;

   localparam int unsigned DEFAULT_WIDTH_A = 8;
   localparam int unsigned DEFAULT_WIDTH_B = 8;
   localparam int unsigned DEFAULT_STAGES  = 8;
   localparam int unsigned DEFAULT_TAG_W   = 4;

   // Widest operand the multiply helper handles.
   localparam int unsigned MAX_W    = 32;
   localparam int unsigned PROD_MAX = 2 * MAX_W;

   function automatic int unsigned prod_width(input int unsigned wa, input int unsigned wb);
      return wa + wb;
   endfunction

   // Operands sit zero-extended in the low wa/wb bits. Signed mode replicates the
   // operand sign bit upward; the low wa+wb bits of the modular product are exact.
   function automatic logic [PROD_MAX-1:0] mul_2sc_u(input logic [MAX_W-1:0] a,
                                                     input logic [MAX_W-1:0] b,
                                                     input int unsigned      wa,
                                                     input int unsigned      wb,
                                                     input logic             signed_mode);
      logic                sa;
      logic                sb;
      logic [PROD_MAX-1:0] ax;
      logic [PROD_MAX-1:0] bx;
      sa = signed_mode & (|(a & (MAX_W'(1) << (wa - 1))));
      sb = signed_mode & (|(b & (MAX_W'(1) << (wb - 1))));
      ax = {{MAX_W{1'b0}}, a} | (sa ? ({PROD_MAX{1'b1}} << wa) : '0);
      bx = {{MAX_W{1'b0}}, b} | (sb ? ({PROD_MAX{1'b1}} << wb) : '0);
      return ax * bx;
   endfunction

endpackage

// File: rtl/mult_stall_pipe.sv
// STAGES-deep chain of {valid, data} registers sharing one enable; the whole
// chain freezes together when advance is low.
module mult_stall_pipe #(
   parameter int unsigned STAGES = 8,
   parameter int unsigned DW     = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          advance,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   output logic [DW-1:0] out_data
);

   logic [STAGES-1:0] valid_q;
   logic [DW-1:0]     data_q [STAGES];

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            data_q[i] <= '0;
         end
      end else if (advance) begin
         valid_q[0] <= in_valid;
         data_q[0]  <= in_data;
         for (int i = 1; i < STAGES; i++) begin
            valid_q[i] <= valid_q[i-1];
            data_q[i]  <= data_q[i-1];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/mult_piped_2sc_stream.sv
// Streaming signed/unsigned multiplier: product formed combinationally, then
// delayed through a stallable pipe together with its tag.
module mult_piped_2sc_stream
   import mult_pkg::*;
#(
   parameter int unsigned WIDTH_A = DEFAULT_WIDTH_A,
   parameter int unsigned WIDTH_B = DEFAULT_WIDTH_B,
   parameter int unsigned STAGES  = DEFAULT_STAGES,
   parameter int unsigned TAG_W   = DEFAULT_TAG_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH_A-1:0]         in_a,
   input  logic [WIDTH_B-1:0]         in_b,
   input  logic                       in_signed,
   input  logic [TAG_W-1:0]           in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH_A+WIDTH_B-1:0] out_y,
   output logic [TAG_W-1:0]           out_tag
);

   localparam int unsigned PW = prod_width(WIDTH_A, WIDTH_B);
   localparam int unsigned DW = PW + TAG_W;

   logic          advance;
   logic [PW-1:0] prod;
   logic [DW-1:0] pipe_out;

   // Global stall: bubbles are not squeezed out, so latency stays fixed.
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance & ~reset;

   assign prod = PW'(mul_2sc_u(MAX_W'(in_a), MAX_W'(in_b), WIDTH_A, WIDTH_B, in_signed));

   mult_stall_pipe #(
      .STAGES (STAGES),
      .DW     (DW)
   ) u_pipe (
      .clk       (clk),
      .reset     (reset),
      .advance   (advance),
      .in_valid  (in_valid),
      .in_data   ({prod, in_tag}),
      .out_valid (out_valid),
      .out_data  (pipe_out)
   );

   assign out_y   = pipe_out[DW-1 -: PW];
   assign out_tag = pipe_out[TAG_W-1:0];

endmodule

// File: tb/tb_mult_piped_2sc_stream.sv
// Directed bench: default 8x8 instance with a scoreboard, plus 12x5 instances
// at 1 and 3 stages for the parameter sweep.
module tb_mult_piped_2sc_stream;

   localparam int unsigned STAGES = 8;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_a;
   logic [7:0]  in_b;
   logic        in_signed;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;
   logic [3:0]  out_tag;

   logic        p_valid;
   logic [11:0] p_a;
   logic [4:0]  p_b;
   logic        p_signed;
   logic [3:0]  p_tag;
   logic        p_out_ready;
   logic        p1_in_ready, p1_valid;
   logic [16:0] p1_y;
   logic [3:0]  p1_tag;
   logic        p3_in_ready, p3_valid;
   logic [16:0] p3_y;
   logic [3:0]  p3_tag;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int n_acc = 0;
   int n_cons = 0;
   bit chk_lat = 1'b1;
   logic [15:0] drv_exp;
   logic [15:0] exp_y [$];
   logic [3:0]  exp_tag [$];
   int          acc_cyc [$];

   mult_piped_2sc_stream u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_y     (out_y),
      .out_tag   (out_tag)
   );

   mult_piped_2sc_stream #(.WIDTH_A(12), .WIDTH_B(5), .STAGES(1), .TAG_W(4)) u_p1 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (p_valid),
      .in_ready  (p1_in_ready),
      .in_a      (p_a),
      .in_b      (p_b),
      .in_signed (p_signed),
      .in_tag    (p_tag),
      .out_valid (p1_valid),
      .out_ready (p_out_ready),
      .out_y     (p1_y),
      .out_tag   (p1_tag)
   );

   mult_piped_2sc_stream #(.WIDTH_A(12), .WIDTH_B(5), .STAGES(3), .TAG_W(4)) u_p3 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (p_valid),
      .in_ready  (p3_in_ready),
      .in_a      (p_a),
      .in_b      (p_b),
      .in_signed (p_signed),
      .in_tag    (p_tag),
      .out_valid (p3_valid),
      .out_ready (p_out_ready),
      .out_y     (p3_y),
      .out_tag   (p3_tag)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b,
                                           input logic s);
      int ia;
      int ib;
      ia = s ? int'($signed(a)) : int'(a);
      ib = s ? int'($signed(b)) : int'(b);
      return 16'(ia * ib);
   endfunction

   // One clock: settle, score the handshakes seen before the edge, then step.
   task automatic cycle();
      #1;
      if (out_valid && !out_ready && exp_y.size() > 0) begin
         check("hold_y", out_y, exp_y[0]);
         check("hold_tag", out_tag, exp_tag[0]);
      end
      if (out_valid && out_ready) begin
         if (exp_y.size() == 0) begin
            check("spurious", out_valid, 0);
         end else begin
            check("y", out_y, exp_y[0]);
            check("tag", out_tag, exp_tag[0]);
            if (chk_lat) check("latency", cyc - acc_cyc[0], STAGES);
            void'(exp_y.pop_front());
            void'(exp_tag.pop_front());
            void'(acc_cyc.pop_front());
            n_cons++;
         end
      end
      if (in_valid && in_ready) begin
         exp_y.push_back(drv_exp);
         exp_tag.push_back(in_tag);
         acc_cyc.push_back(cyc);
         n_acc++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s,
                       input logic [3:0] tag, input logic [15:0] exp);
      in_valid  = 1'b1;
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_tag    = tag;
      drv_exp   = exp;
      cycle();
      in_valid  = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_y.size() > 0; k++) cycle();
      check("drain_empty", exp_y.size(), 0);
   endtask

   initial begin
      int acc0;
      int cons0;
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rs;

      reset = 1'b1;
      in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
      out_ready = 1'b1; drv_exp = '0;
      p_valid = 1'b0; p_a = '0; p_b = '0; p_signed = 1'b0; p_tag = '0; p_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_y", out_y, 0);
      check("rst_out_tag", out_tag, 0);
      check("rst_in_ready", in_ready, 0);
      reset = 1'b0;
      #1;
      check("rel_in_ready", in_ready, 1);

      // Directed signed/unsigned corners.
      send(8'h80, 8'h80, 1'b1, 4'd3, 16'h4000); drain();
      send(8'h80, 8'h7F, 1'b1, 4'd4, 16'hC080); drain();
      send(8'hFF, 8'h01, 1'b1, 4'd5, 16'hFFFF); drain();
      send(8'h00, 8'h85, 1'b1, 4'd6, 16'h0000); drain();
      send(8'hFF, 8'hFF, 1'b0, 4'd7, 16'hFE01); drain();

      // Mixed modes back to back; equal latency keeps them consecutive and ordered.
      send(8'hFF, 8'hFF, 1'b0, 4'd8, 16'hFE01);
      send(8'hFF, 8'hFF, 1'b1, 4'd9, 16'h0001);
      drain();

      // 20 back-to-back random transactions.
      cons0 = n_cons;
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rs = 1'($urandom_range(0, 1));
         in_valid = 1'b1; in_a = ra; in_b = rb; in_signed = rs; in_tag = 4'(i);
         drv_exp = ref_mul(ra, rb, rs);
         cycle();
      end
      in_valid = 1'b0;
      drain();
      check("stream_count", n_cons - cons0, 20);

      // Back-pressure: fill, stall 5 cycles, release.
      chk_lat = 1'b0;
      out_ready = 1'b0;
      acc0 = n_acc;
      cons0 = n_cons;
      for (int k = 0; k < 13; k++) begin
         ra = 8'(k * 17 + 1);
         rb = 8'(k * 29 + 3);
         rs = 1'(k);
         in_valid = 1'b1; in_a = ra; in_b = rb; in_signed = rs; in_tag = 4'(k + 2);
         drv_exp = ref_mul(ra, rb, rs);
         cycle();
         if (k >= 7 && k < 12) check("bp_in_ready", in_ready, 0);
      end
      check("bp_accepts", n_acc - acc0, STAGES);
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      check("bp_consumes", n_cons - cons0, n_acc - acc0);
      chk_lat = 1'b1;

      // Reset with 4 transactions in flight.
      for (int k = 0; k < 4; k++) begin
         in_valid = 1'b1; in_a = 8'(k + 5); in_b = 8'(k + 9); in_signed = 1'b0;
         in_tag = 4'(k + 10); drv_exp = ref_mul(8'(k + 5), 8'(k + 9), 1'b0);
         cycle();
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_out_y", out_y, 0);
      check("mid_rst_in_ready", in_ready, 0);
      exp_y.delete();
      exp_tag.delete();
      acc_cyc.delete();
      reset = 1'b0;
      #1;
      check("mid_rel_in_ready", in_ready, 1);
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("stale", out_valid, 0);
      end

      // 12x5 instances: -2048 * -16 at one and three stages.
      p_valid = 1'b1; p_a = 12'h800; p_b = 5'h10; p_signed = 1'b1; p_tag = 4'd9;
      #1;
      check("p1_in_ready", p1_in_ready, 1);
      @(posedge clk);
      #1;
      p_valid = 1'b0;
      check("p1_valid", p1_valid, 1);
      check("p1_y", p1_y, 17'h08000);
      check("p1_tag", p1_tag, 9);
      check("p3_early", p3_valid, 0);
      @(posedge clk);
      #1;
      check("p1_gone", p1_valid, 0);
      check("p3_early2", p3_valid, 0);
      @(posedge clk);
      #1;
      check("p3_valid", p3_valid, 1);
      check("p3_y", p3_y, 17'h08000);
      check("p3_tag", p3_tag, 9);

      p_valid = 1'b1; p_a = 12'hFFF; p_b = 5'h1F; p_signed = 1'b0; p_tag = 4'd1;
      @(posedge clk);
      #1;
      check("p1_unsigned", p1_y, 17'h1EFE1);
      p_a = 12'h800; p_b = 5'h0F; p_signed = 1'b1; p_tag = 4'd2;
      @(posedge clk);
      #1;
      p_valid = 1'b0;
      check("p1_signed_mix", p1_y, 17'h18800);
      check("p1_mix_tag", p1_tag, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
